// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I_BUSY,
    ARB_D_BUSY
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between the fetch
// (I-side) and memory (D-side) stages. Round-robin on conflicts, one
// access in flight at a time, single-cycle ready pulse at completion.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_d
);

  localparam int                CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  arb_state_t        state_q, state_d;
  arb_grant_t        last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic busy;
  logic last_cycle;

  assign busy       = (state_q != ARB_IDLE);
  assign last_cycle = busy && (cnt_q == CNT_LAST);

  // State, counter and latched request registers.
  // NOTE: the latched address/data registers are reset too, so mem_* and
  // rdata are provably 0 out of reset rather than carrying X into the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GNT_I;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state: grant selection in IDLE, countdown while busy.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        // D wins when alone, or on a tie when I was served last.
        if (d_req && (!i_req || last_grant_q == GNT_I)) begin
          state_d      = ARB_D_BUSY;
          last_grant_d = GNT_D;
          cnt_d        = CNT_LOAD;
          addr_d       = d_addr;
          we_d         = d_we;
          wdata_d      = d_wdata;
        end else if (i_req) begin
          state_d      = ARB_I_BUSY;
          last_grant_d = GNT_I;
          cnt_d        = CNT_LOAD;
          addr_d       = i_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
        end
      end
      ARB_I_BUSY, ARB_D_BUSY: begin
        cnt_d = cnt_q - CNT_LAST;
        if (last_cycle) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory-side and requester-side outputs, all decoded from current state.
  always_comb begin
    mem_en    = busy;
    mem_we    = (state_q == ARB_D_BUSY) && we_q;
    mem_addr  = busy ? addr_q : '0;
    mem_wdata = busy ? wdata_q : '0;
    i_ready   = last_cycle && (state_q == ARB_I_BUSY);
    d_ready   = last_cycle && (state_q == ARB_D_BUSY);
    i_rdata   = i_ready ? mem_rdata : '0;
    d_rdata   = (d_ready && !we_q) ? mem_rdata : '0;
    grant_d   = (last_grant_q == GNT_D);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LATENCY=2 instance for the
// main scenarios and one MEM_LATENCY=1 instance for the short-latency case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  // Instance A, MEM_LATENCY = 2.
  logic        i_req, i_ready, d_req, d_we, d_ready;
  logic        mem_en, mem_we, grant_d;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Instance B, MEM_LATENCY = 1.
  logic        b_i_req, b_i_ready, b_d_req, b_d_we, b_d_ready;
  logic        b_mem_en, b_mem_we, b_grant_d;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RDATA = 32'h8C02_0004;
  localparam logic [31:0] B_RDATA = 32'h0000_1234;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_d(grant_d)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .grant_d(b_grant_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle step; all driving and sampling happens on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset with both requests high ----------------
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
    mem_rdata = RDATA;
    b_i_req = 1'b0; b_i_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 32'h0; b_d_wdata = 32'h0; b_mem_rdata = B_RDATA;
    #12;
    check("rst mem_en",    {31'b0, mem_en},  32'h0);
    check("rst mem_we",    {31'b0, mem_we},  32'h0);
    check("rst mem_addr",  mem_addr,         32'h0);
    check("rst mem_wdata", mem_wdata,        32'h0);
    check("rst i_ready",   {31'b0, i_ready}, 32'h0);
    check("rst d_ready",   {31'b0, d_ready}, 32'h0);
    check("rst i_rdata",   i_rdata,          32'h0);
    check("rst d_rdata",   d_rdata,          32'h0);
    check("rst grant_d",   {31'b0, grant_d}, 32'h0);
    check("rst b_mem_en",  {31'b0, b_mem_en}, 32'h0);

    // ---------------- tie, both held: D, I, D alternation ----------------
    cyc();
    reset = 1'b1;                       // cycle 0: IDLE, tie
    check("tie c0 mem_en", {31'b0, mem_en}, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      logic exp_d, exp_i, exp_g, exp_en;
      cyc();
      exp_d  = (c == 2) || (c == 8);
      exp_i  = (c == 5);
      exp_g  = (c <= 3) || (c >= 7);
      exp_en = !((c == 3) || (c == 6));
      check($sformatf("tie c%0d d_ready", c), {31'b0, d_ready}, {31'b0, exp_d});
      check($sformatf("tie c%0d i_ready", c), {31'b0, i_ready}, {31'b0, exp_i});
      check($sformatf("tie c%0d grant_d", c), {31'b0, grant_d}, {31'b0, exp_g});
      check($sformatf("tie c%0d mem_en",  c), {31'b0, mem_en},  {31'b0, exp_en});
      check($sformatf("tie c%0d d_rdata", c), d_rdata, exp_d ? RDATA : 32'h0);
      check($sformatf("tie c%0d i_rdata", c), i_rdata, exp_i ? RDATA : 32'h0);
      if (exp_en)
        check($sformatf("tie c%0d mem_addr", c), mem_addr, exp_g ? 32'h100 : 32'h40);
    end
    i_req = 1'b0; d_req = 1'b0;
    cyc();
    check("tie idle mem_en", {31'b0, mem_en}, 32'h0);

    // ---------------- single fetch, addr change mid-access ignored ----------------
    i_req = 1'b1; i_addr = 32'h40;      // cycle 0
    check("fetch c0 i_rdata", i_rdata, 32'h0);
    cyc();                              // cycle 1
    check("fetch c1 mem_en",   {31'b0, mem_en},  32'h1);
    check("fetch c1 mem_addr", mem_addr,         32'h40);
    check("fetch c1 mem_we",   {31'b0, mem_we},  32'h0);
    check("fetch c1 i_ready",  {31'b0, i_ready}, 32'h0);
    check("fetch c1 i_rdata",  i_rdata,          32'h0);
    i_addr = 32'h80;
    cyc();                              // cycle 2
    check("fetch c2 mem_addr", mem_addr,         32'h40);
    check("fetch c2 i_ready",  {31'b0, i_ready}, 32'h1);
    check("fetch c2 i_rdata",  i_rdata,          RDATA);
    check("fetch c2 d_ready",  {31'b0, d_ready}, 32'h0);
    i_req = 1'b0;
    cyc();                              // cycle 3
    check("fetch c3 i_ready",  {31'b0, i_ready}, 32'h0);
    check("fetch c3 i_rdata",  i_rdata,          32'h0);
    check("fetch c3 mem_en",   {31'b0, mem_en},  32'h0);

    // ---------------- store, request dropped mid-access ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7;   // cycle 0
    cyc();                              // cycle 1
    check("st c1 mem_we",    {31'b0, mem_we},  32'h1);
    check("st c1 mem_wdata", mem_wdata,        32'h7);
    check("st c1 mem_addr",  mem_addr,         32'h54);
    check("st c1 grant_d",   {31'b0, grant_d}, 32'h1);
    d_req = 1'b0; d_wdata = 32'hFF;
    cyc();                              // cycle 2
    check("st c2 mem_we",    {31'b0, mem_we},  32'h1);
    check("st c2 mem_wdata", mem_wdata,        32'h7);
    check("st c2 d_ready",   {31'b0, d_ready}, 32'h1);
    check("st c2 d_rdata",   d_rdata,          32'h0);
    cyc();                              // cycle 3
    check("st c3 mem_we",    {31'b0, mem_we},  32'h0);
    check("st c3 d_ready",   {31'b0, d_ready}, 32'h0);
    check("st c3 mem_en",    {31'b0, mem_en},  32'h0);
    d_we = 1'b0;

    // ---------------- reset during an I_BUSY fetch ----------------
    i_req = 1'b1; i_addr = 32'h60;      // cycle 0
    cyc();                              // cycle 1
    check("rma c1 mem_en", {31'b0, mem_en}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rma async mem_en",  {31'b0, mem_en},  32'h0);
    check("rma async mem_we",  {31'b0, mem_we},  32'h0);
    check("rma async i_ready", {31'b0, i_ready}, 32'h0);
    cyc();
    check("rma held i_ready",  {31'b0, i_ready}, 32'h0);
    reset = 1'b1;                       // new cycle 0, i_req still high
    cyc();                              // cycle 1
    check("rma re c1 mem_en",  {31'b0, mem_en},  32'h1);
    check("rma re c1 i_ready", {31'b0, i_ready}, 32'h0);
    check("rma re c1 mem_addr", mem_addr,        32'h60);
    cyc();                              // cycle 2
    check("rma re c2 i_ready", {31'b0, i_ready}, 32'h1);
    i_req = 1'b0;
    cyc();

    // ---------------- MEM_LATENCY = 1, i_req held ----------------
    b_i_req = 1'b1; b_i_addr = 32'h0;   // cycle 0
    for (int c = 1; c <= 6; c++) begin
      logic exp_r;
      cyc();
      exp_r = (c % 2) == 1;
      check($sformatf("l1 c%0d i_ready", c), {31'b0, b_i_ready}, {31'b0, exp_r});
      check($sformatf("l1 c%0d mem_en",  c), {31'b0, b_mem_en},  {31'b0, exp_r});
      check($sformatf("l1 c%0d i_rdata", c), b_i_rdata, exp_r ? B_RDATA : 32'h0);
      if (exp_r) begin
        check($sformatf("l1 c%0d mem_addr", c), b_mem_addr, 32'((c - 1) * 2));
        b_i_addr = b_i_addr + 32'h4;
      end
    end
    b_i_req = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipelined core's fetch stage (I-side) and memory stage (D-side).
- Serialises accesses, applies round-robin priority on conflicts and returns per-requester ready pulses.
- The core derives its stalls from these: stall_f = i_req & ~i_ready; stall_m = d_req & ~d_ready.
- Sits between mips_core and the memory model, replacing the separate imem/dmem ports.

Parameters:
- MEM_LATENCY, 2, cycles a granted access occupies the memory; read data is valid in the last of them; legal range >= 1.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock, all state on its rising edge.
- reset  input  1  asynchronous, active-low reset; port named reset as elsewhere in the core.
- i_req  input  1  fetch request; held high with i_addr stable until i_ready.
- i_addr  input  ADDR_W  fetch address (pc).
- i_ready  output  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  output  DATA_W  fetched instruction.
- d_req  input  1  data request; held high with d_we, d_addr and d_wdata stable until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address (alu_out).
- d_wdata  input  DATA_W  store data.
- d_ready  output  1  one-cycle pulse: data access complete.
- d_rdata  output  DATA_W  load data, valid with d_ready on loads.
- mem_en  output  1  memory access active.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid in the last busy cycle.
- grant_d  output  1  1 while the current or last grant is the D-side (debug).

Behaviour:
- Reset (reset = 0), asynchronous, effective immediately:
  - state = IDLE, counter = 0, last_grant = I.
  - All outputs 0, including the mem_* outputs, ready pulses and rdata.
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - No request: stay in IDLE.
  - Only d_req: go to D_BUSY.
  - Only i_req: go to I_BUSY.
  - Both requests: grant the side that is not last_grant; at the first tie after reset D wins.
  - On a grant: latch address, we and wdata into internal registers; load counter with MEM_LATENCY; update last_grant and grant_d.
  - mem_en = 0 in IDLE.
- I_BUSY / D_BUSY:
  - mem_en = 1 and mem_addr / mem_wdata driven from the latched registers.
  - mem_we = latched we in D_BUSY; mem_we = 0 in I_BUSY.
  - Counter decrements each cycle.
  - Last busy cycle (counter == 1): assert the side's ready combinationally; drive its rdata = mem_rdata (d_rdata = 0 on stores); next state IDLE.
- Timing:
  - Grant-to-ready = MEM_LATENCY cycles after the IDLE grant cycle.
  - Back-to-back throughput = one access per MEM_LATENCY + 1 cycles.
- rdata outputs are 0 whenever the corresponding ready is 0; i_ready and d_ready are never high in the same cycle.
- Inputs are sampled only in IDLE. Changes to req, addr or data during BUSY are ignored.
- Requester drops req mid-access: the access still completes and the ready pulse is still issued.
- A req still high in the IDLE cycle after ready is treated as a new access; the pipeline has advanced by then.
- Continuous conflict: grants alternate D, I, D, I; neither side waits more than one foreign access.
- Reset mid-access: the access is abandoned with no ready pulse; mem_en and mem_we fall immediately.
- Counter width is $clog2(MEM_LATENCY+1). MEM_LATENCY = 1 is legal: ready in the cycle after the grant.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_I_BUSY, ARB_D_BUSY};
  - typedef enum logic {GNT_I, GNT_D} arb_grant_t;
  - localparam defaults for ADDR_W and DATA_W.
- Single module, no sub-module: counter, FSM and request latch are inline.

Test Plan:
- Reset: hold reset = 0 with both reqs high -> all outputs 0. Release -> D-side is granted first.
- Single fetch, MEM_LATENCY = 2: i_req = 1, i_addr = 0x0040 at cycle 0.
  - mem_en = 1 and mem_addr = 0x0040 in cycles 1-2.
  - i_ready = 1 in cycle 2 with i_rdata = 0x8C020004 (mem_rdata); i_rdata = 0 in other cycles.
- Store: d_req = 1, d_we = 1, d_addr = 0x54, d_wdata = 0x00000007.
  - mem_we = 1 and mem_wdata = 0x7 in cycles 1-2.
  - d_ready pulse in cycle 2 with d_rdata = 0; mem_we = 0 in cycle 3.
- Tie at cycle 0, both reqs held:
  - d_ready in cycle 2, i_ready in cycle 5, next d_ready in cycle 8, in strict alternation.
  - Check no pulse overlap and that grant_d toggles.
- Reset mid-access: assert reset during cycle 1 of an I_BUSY fetch.
  - mem_en = 0 immediately; no i_ready.
  - After release, i_req is regranted from IDLE with a full MEM_LATENCY wait.
- MEM_LATENCY = 1 build, i_req held continuously -> i_ready in cycles 1, 3, 5, and mem_addr follows each new i_addr.
